// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: counters, sync/blank decodes, line/frame strobes.
// Optional interlace support (field toggling, odd-field extra line, half-line VSync) via VIDEO_TIMING_INTERLACE_EN.
module video_timing_gen #(
  parameter int H_ACTIVE   = 320,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 32,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 240,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 16,
  parameter int HCNT_WIDTH = 10,
  parameter int VCNT_WIDTH = 9,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce_pix,
  input  logic                  interlace,
  output logic [HCNT_WIDTH-1:0] hcount,
  output logic [VCNT_WIDTH-1:0] vcount,
  output logic                  HSync,
  output logic                  VSync,
  output logic                  HBlank,
  output logic                  VBlank,
  output logic                  de,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  field
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCNT_WIDTH-1:0] H_LAST   = HCNT_WIDTH'(H_TOTAL - 1);
  localparam logic [HCNT_WIDTH-1:0] HB_START = HCNT_WIDTH'(H_ACTIVE);
  localparam logic [HCNT_WIDTH-1:0] HS_START = HCNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [HCNT_WIDTH-1:0] HS_END   = HCNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_WIDTH-1:0] VB_START = VCNT_WIDTH'(V_ACTIVE);
  localparam logic [VCNT_WIDTH-1:0] VS_START = VCNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [VCNT_WIDTH-1:0] VS_END   = VCNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCNT_WIDTH-1:0] V_LAST   = VCNT_WIDTH'(V_TOTAL - 1);
`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam logic [HCNT_WIDTH-1:0] H_HALF   = HCNT_WIDTH'(H_TOTAL / 2);
  localparam logic [VCNT_WIDTH-1:0] V_LAST_ODD = VCNT_WIDTH'(V_TOTAL);
`else
  logic unused_interlace;
  assign unused_interlace = interlace;
`endif

  // Cleared by reset so the first enabled pixel after reset lands on (0,0) with both strobes.
  logic running;

  logic [HCNT_WIDTH-1:0] h_nxt;
  logic [VCNT_WIDTH-1:0] v_nxt;
  logic [VCNT_WIDTH-1:0] v_last;
  logic                  field_nxt;
  logic                  line_wrap;
  logic                  frame_wrap;
  logic                  line_start_nxt;
  logic                  frame_start_nxt;
  logic                  hblank_nxt;
  logic                  vblank_nxt;
  logic                  hsync_act;
  logic                  vsync_act;

  always_comb begin
    v_last = V_LAST;
`ifdef VIDEO_TIMING_INTERLACE_EN
    if (field) v_last = V_LAST_ODD;
`endif
    line_wrap  = (hcount == H_LAST);
    frame_wrap = line_wrap && (vcount == v_last);
    h_nxt      = hcount + HCNT_WIDTH'(1);
    v_nxt      = vcount;
    field_nxt  = field;
    line_start_nxt  = line_wrap;
    frame_start_nxt = frame_wrap;
    if (!running) begin
      h_nxt           = '0;
      v_nxt           = '0;
      field_nxt       = 1'b0;
      line_start_nxt  = 1'b1;
      frame_start_nxt = 1'b1;
    end else if (line_wrap) begin
      h_nxt = '0;
      if (frame_wrap) begin
        v_nxt = '0;
`ifdef VIDEO_TIMING_INTERLACE_EN
        field_nxt = interlace & ~field;
`else
        field_nxt = 1'b0;
`endif
      end else begin
        v_nxt = vcount + VCNT_WIDTH'(1);
      end
    end
  end

  // Decodes look at the next coordinates so flags line up with the registered counters.
  always_comb begin
    hblank_nxt = (h_nxt >= HB_START);
    vblank_nxt = (v_nxt >= VB_START);
    hsync_act  = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vsync_act  = (v_nxt >= VS_START) && (v_nxt < VS_END);
`ifdef VIDEO_TIMING_INTERLACE_EN
    if (field_nxt) begin
      vsync_act = ((v_nxt > VS_START) || ((v_nxt == VS_START) && (h_nxt >= H_HALF))) &&
                  ((v_nxt < VS_END)   || ((v_nxt == VS_END)   && (h_nxt <  H_HALF)));
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      running     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      HSync       <= ~HS_POL;
      VSync       <= ~VS_POL;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
    end else if (ce_pix) begin
      running     <= 1'b1;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      HSync       <= hsync_act ? HS_POL : ~HS_POL;
      VSync       <= vsync_act ? VS_POL : ~VS_POL;
      HBlank      <= hblank_nxt;
      VBlank      <= vblank_nxt;
      de          <= ~(hblank_nxt | vblank_nxt);
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
      field       <= field_nxt;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
